// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared state, instruction-class, opcode/func and ALU encodings for the multi-cycle controller
package mc_ctrl_fsm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [3:0] {C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} cls_e;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;
endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// mc_decode: combinational op/func classifier; anything unrecognised is C_ILL
module mc_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output cls_e       cls,
  output logic       illegal
);
  always_comb begin
    cls = (op == OP_R)   ? ((func == F_ADDU) ? C_ADDU :
                            (func == F_SUBU) ? C_SUBU :
                            (func == F_JR)   ? C_JR   :
                            (func == F_SLL)  ? C_NOP  : C_ILL) :
          (op == OP_ORI) ? C_ORI :
          (op == OP_LUI) ? C_LUI :
          (op == OP_LW)  ? C_LW  :
          (op == OP_SW)  ? C_SW  :
          (op == OP_BEQ) ? C_BEQ :
          (op == OP_J)   ? C_J   :
          (op == OP_JAL) ? C_JAL : C_ILL;
    illegal = (cls == C_ILL);
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer with memory handshake, timeout trap and retire counter
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             grf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic [2:0]       state_o,
  output logic             instr_done,
  output logic             illegal,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);
  localparam logic [7:0] WMAX = 8'(WAIT_MAX);
  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic             dec_ill, alu_on;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;

  mc_decode u_dec (.op(op), .func(func), .cls(dec_cls), .illegal(dec_ill));

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NOP;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_q + CNT_W'(instr_done);
    end

  // ALU controls stay stable from EXEC through MEM/WB so the datapath result does not move
  always_comb begin
    alu_on  = state_q inside {S_EXEC, S_MEM, S_WB};
    alu_src = alu_on && (cls_q inside {C_ORI, C_LUI, C_LW, C_SW});
    ext_op  = alu_on && (cls_q inside {C_LW, C_SW, C_BEQ});
    alu_op  = !alu_on ? ALU_ADD :
              (cls_q inside {C_SUBU, C_BEQ}) ? ALU_SUB :
              (cls_q == C_ORI) ? ALU_OR :
              (cls_q == C_LUI) ? ALU_LUI : ALU_ADD;
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = wait_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = 2'd0;
    grf_we     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WMAX) state_d = S_TRAP;
        else wait_d = wait_q + 8'd1;
      end
      S_DECODE: begin
        cls_d = dec_cls;
        illegal = dec_ill;
        instr_done = dec_ill;
        state_d = dec_ill ? S_FETCH : S_EXEC;
      end
      S_EXEC:
        case (cls_q)
          C_BEQ: begin pc_we = alu_zero; npc_sel = 2'd1; instr_done = 1'b1; state_d = S_FETCH; end
          C_J:   begin pc_we = 1'b1; npc_sel = 2'd2; instr_done = 1'b1; state_d = S_FETCH; end
          C_JAL: begin
            pc_we = 1'b1; npc_sel = 2'd2; grf_we = 1'b1; reg_dst = 2'd2; wd_sel = 2'd2;
            instr_done = 1'b1; state_d = S_FETCH;
          end
          C_JR:  begin pc_we = 1'b1; npc_sel = 2'd3; instr_done = 1'b1; state_d = S_FETCH; end
          C_NOP: begin instr_done = 1'b1; state_d = S_FETCH; end
          C_LW, C_SW: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_SW);
        if (mem_ready) begin
          instr_done = (cls_q == C_SW);
          state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
        end else if (wait_q == WMAX) state_d = S_TRAP;
        else wait_d = wait_q + 8'd1;
      end
      S_WB: begin
        grf_we = 1'b1;
        reg_dst = (cls_q inside {C_ADDU, C_SUBU}) ? 2'd1 : 2'd0;
        wd_sel = (cls_q == C_LW) ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  assign state_o = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench; per-cycle expected controls are queued as stimulus is driven
module tb_mc_ctrl_fsm;
  localparam int WMAX = 15;
  typedef enum int {K_ADDU, K_SUBU, K_JR, K_NOP, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_e;
  typedef struct packed {
    logic req, we, irwe, pcwe;
    logic [1:0] npc;
    logic grf;
    logic [1:0] rd, wd;
    logic src, ext;
    logic [2:0] aop;
    logic done, ill, trp;
  } ctl_t;
  typedef struct packed {
    logic [2:0]  st;
    ctl_t        c;
    logic [31:0] ret;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, alu_zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic mem_req, mem_we, ir_we, pc_we, grf_we, alu_src, ext_op, instr_done, illegal, trap;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op, state_o;
  logic [31:0] retired;
  ctl_t obs;
  exp_t q[$];
  exp_t e_m;
  int n_chk = 0, n_pass = 0;
  logic [31:0] ret_m = '0;

  mc_ctrl_fsm #(.WAIT_MAX(WMAX), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
    .grf_we(grf_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .state_o(state_o), .instr_done(instr_done), .illegal(illegal),
    .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;
  assign obs = {mem_req, mem_we, ir_we, pc_we, npc_sel, grf_we, reg_dst, wd_sel,
                alu_src, ext_op, alu_op, instr_done, illegal, trap};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      e_m = q.pop_front();
      check("state", 64'(state_o), 64'(e_m.st));
      check("ctl", 64'(obs), 64'(e_m.c));
      check("retired", 64'(retired), 64'(e_m.ret));
    end

  task automatic cyc(input logic rdy, input logic [2:0] st, input ctl_t c);
    exp_t e;
    mem_ready = rdy;
    e.st = st;
    e.c = c;
    e.ret = ret_m;
    q.push_back(e);
    if (c.done) ret_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input kind_e k, input logic z, input int fw, input int mw, input bit abort = 1'b0);
    ctl_t c, a;
    case (k)
      K_ADDU: begin op = 6'h00; func = 6'h21; end
      K_SUBU: begin op = 6'h00; func = 6'h23; end
      K_JR:   begin op = 6'h00; func = 6'h08; end
      K_NOP:  begin op = 6'h00; func = 6'h00; end
      K_ORI:  begin op = 6'h0d; func = 6'($urandom); end
      K_LUI:  begin op = 6'h0f; func = 6'($urandom); end
      K_LW:   begin op = 6'h23; func = 6'($urandom); end
      K_SW:   begin op = 6'h2b; func = 6'($urandom); end
      K_BEQ:  begin op = 6'h04; func = 6'($urandom); end
      K_J:    begin op = 6'h02; func = 6'($urandom); end
      K_JAL:  begin op = 6'h03; func = 6'($urandom); end
      default: begin op = 6'h3f; func = 6'h00; end
    endcase
    alu_zero = z;
    a = '0;
    a.src = k inside {K_ORI, K_LUI, K_LW, K_SW};
    a.ext = k inside {K_LW, K_SW, K_BEQ};
    a.aop = (k inside {K_SUBU, K_BEQ}) ? 3'd1 : (k == K_ORI) ? 3'd2 : (k == K_LUI) ? 3'd3 : 3'd0;
    c = '0; c.req = 1'b1;
    for (int i = 0; i < fw; i++) cyc(1'b0, 3'd1, c);
    c.irwe = 1'b1; c.pcwe = 1'b1;
    cyc(1'b1, 3'd1, c);
    if (k == K_ILL) begin
      c = '0; c.ill = 1'b1; c.done = 1'b1;
      cyc(1'b1, 3'd2, c);
      return;
    end
    cyc(1'b1, 3'd2, '0);
    c = a;
    case (k)
      K_BEQ: begin c.pcwe = z; c.npc = 2'd1; c.done = 1'b1; cyc(1'b1, 3'd3, c); return; end
      K_J:   begin c.pcwe = 1'b1; c.npc = 2'd2; c.done = 1'b1; cyc(1'b1, 3'd3, c); return; end
      K_JAL: begin
        c.pcwe = 1'b1; c.npc = 2'd2; c.grf = 1'b1; c.rd = 2'd2; c.wd = 2'd2; c.done = 1'b1;
        cyc(1'b1, 3'd3, c);
        return;
      end
      K_JR:  begin c.pcwe = 1'b1; c.npc = 2'd3; c.done = 1'b1; cyc(1'b1, 3'd3, c); return; end
      K_NOP: begin c.done = 1'b1; cyc(1'b1, 3'd3, c); return; end
      default: cyc(1'b1, 3'd3, c);
    endcase
    if (k inside {K_LW, K_SW}) begin
      c = a; c.req = 1'b1; c.we = (k == K_SW);
      for (int i = 0; i < mw; i++) cyc(1'b0, 3'd4, c);
      if (abort) return;
      c.done = (k == K_SW);
      cyc(1'b1, 3'd4, c);
      if (k == K_SW) return;
    end
    c = a; c.grf = 1'b1; c.done = 1'b1;
    c.rd = (k inside {K_ADDU, K_SUBU}) ? 2'd1 : 2'd0;
    c.wd = (k == K_LW) ? 2'd1 : 2'd0;
    cyc(1'b1, 3'd5, c);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 64'(state_o), 64'd0);
    check({tag, "_ctl"}, 64'(obs), 64'd0);
    check({tag, "_ret"}, 64'(retired), 64'd0);
  endtask

  task automatic leave_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ret_m = '0;
    cyc(1'b0, 3'd0, '0);
  endtask

  initial begin
    ctl_t c;
    #3;
    reset_checks("rst");
    leave_reset();
    run(K_ADDU, 1'b0, 0, 0);
    run(K_LW, 1'b0, 0, 3);
    run(K_BEQ, 1'b1, 0, 0);
    run(K_BEQ, 1'b0, 0, 0);
    run(K_JAL, 1'b0, 0, 0);
    run(K_JR, 1'b0, 0, 0);
    run(K_ILL, 1'b0, 0, 0);
    run(K_SUBU, 1'b0, 2, 0);
    run(K_ORI, 1'b0, 0, 0);
    run(K_LUI, 1'b1, 1, 0);
    run(K_SW, 1'b0, 1, 2);
    run(K_J, 1'b0, 0, 0);
    run(K_NOP, 1'b0, 0, 0);
    run(K_LW, 1'b0, WMAX, 10);
    run(K_SW, 1'b0, 0, WMAX);
    c = '0; c.req = 1'b1;
    for (int i = 0; i <= WMAX; i++) cyc(1'b0, 3'd1, c);
    c = '0; c.trp = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd6, c);
    #2 reset = 1'b1;
    #1 reset_checks("trap_rst");
    leave_reset();
    run(K_LW, 1'b0, 0, 2, 1'b1);
    #2 reset = 1'b1;
    #1 reset_checks("mem_rst");
    leave_reset();
    run(K_ADDU, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    if (q.size() != 0) check("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
